vector_accumulate: RTL and testbench
====================================

VECTOR_ACCUMULATE -- requirements
Module: vector_accumulate

Interface
REQ-001 Parameter word_size, default 24, width of each signed input lane element.
REQ-002 Parameter lanes, default 4, number of elements presented per input beat.
REQ-003 Parameter acc_size, default 32, width of the signed accumulator and result (acc_size >= word_size + clog2(lanes)).
REQ-004 Parameter len_size, default 8, width of the beat-count field.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a reduction; sampled only in IDLE.
REQ-008 len  input  len_size  number of input beats in the reduction, sampled with start.
REQ-009 sat_mode  input  1  0 = wrap-around arithmetic, 1 = signed saturation; sampled with start.
REQ-010 data_in  input  lanes*word_size  packed signed elements; lane 0 in the LSBs.
REQ-011 in_valid  input  1  data_in carries a valid beat.
REQ-012 in_ready  output  1  block accepts a beat this cycle.
REQ-013 sum  output  acc_size  signed accumulated result.
REQ-014 overflow  output  1  sticky flag; at least one signed overflow occurred in the current reduction.
REQ-015 out_valid  output  1  sum and overflow are final.
REQ-016 out_ready  input  1  consumer acknowledges the result.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-019 IDLE: start=1 with len>0 SHALL clear sum and overflow, load the beat counter with len, latch sat_mode, and go to ACC.
REQ-020 IDLE: start=1 with len=0 SHALL clear sum and overflow and go directly to DONE; out_valid is high the next cycle with sum=0.
REQ-021 in_ready SHALL equal 1 only in ACC; a beat is consumed on a cycle with in_valid=1 and in_ready=1.
REQ-022 Per consumed beat: sign-extend every lane to acc_size, add all lanes plus the current sum, and register the result in a single cycle.
REQ-023 Cycles with in_valid=0 in ACC SHALL leave sum, overflow and the counter unchanged.
REQ-024 Overflow detection uses the exact (acc_size+clog2(lanes)+1)-bit sum; overflow is set when the exact value lies outside the signed acc_size range.
REQ-025 In wrap mode, sum SHALL take the low acc_size bits of the exact sum.
REQ-026 In saturation mode, sum SHALL clamp to 2^(acc_size-1)-1 or -2^(acc_size-1); later beats continue from the clamped value.
REQ-027 The counter SHALL decrement per consumed beat; on the beat that brings it to 0 the FSM goes to DONE.
REQ-028 Latency: out_valid SHALL rise on the cycle after the final beat is consumed.
REQ-029 DONE: out_valid=1; sum and overflow SHALL hold stable until out_ready=1, then the FSM returns to IDLE and out_valid falls next cycle.
REQ-030 start SHALL be ignored in ACC and DONE, including in the same cycle as a DONE->IDLE handshake.
REQ-031 sum and overflow SHALL retain the last result in IDLE until the next start.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, sum=0, overflow=0, counter=0 and latched mode=0; consequently in_ready=0, out_valid=0 and busy=0.
REQ-033 Reset asserted mid-reduction SHALL abandon that reduction with no result produced; the first start after reset release begins a fresh reduction.

Structure
REQ-034 The state encoding (IDLE, ACC, DONE) and the mode constants (WRAP, SAT) SHALL live in a shared package vacc_pkg.
REQ-035 The lane sign-extension and summation SHALL be one combinational sub-module, vacc_lane_reduce, parameterised by word_size, lanes and output width.

Verification (lanes=4, word_size=24, acc_size=32)
REQ-036 Basic: start with len=2 and sat_mode=0, beats {1,2,3,4} then {5,6,7,8} -> out_valid high the cycle after beat 2 with sum=36 and overflow=0.
REQ-037 Negative and gaps: len=3, three beats of {-1,-1,-1,-1} with in_valid low two cycles between beats -> sum=0xFFFFFFF4 (-12).
REQ-038 Saturation: 65 beats with every lane at 0x7FFFFF and sat_mode=1 -> sum=0x7FFFFFFF, overflow=1. The same stimulus with sat_mode=0 -> sum=-2113929476, overflow=1. After 64 beats only -> sum=2147483392, overflow=0.
REQ-039 Backpressure: in DONE, hold out_ready=0 for 5 cycles while pulsing start and in_valid -> sum stable, in_ready=0, no new reduction; out_ready=1 -> IDLE and busy=0 next cycle.
REQ-040 len=0: start with len=0 -> out_valid on the next cycle with sum=0 and no beat consumed.
REQ-041 Mid-operation reset: rst asserted after 1 of 3 beats -> all outputs 0 immediately; a following start with len=1 and beat {10,0,0,0} -> sum=10.

Source files
------------

// File: rtl/vacc_pkg.sv
// vacc_pkg -- shared definitions for the vector accumulator.
//   vacc_state_t : controller states (IDLE, ACC, DONE)
//   MODE_WRAP    : wrap-around arithmetic (sat_mode = 0)
//   MODE_SAT     : signed saturation      (sat_mode = 1)
package vacc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } vacc_state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/vacc_lane_reduce.sv
// vacc_lane_reduce -- combinational sum of all lanes of one input beat.
// Every lane is sign-extended to out_size bits before it is added, so the
// result is exact as long as out_size >= word_size + clog2(lanes).
//   data_in  : lanes*word_size packed signed elements, lane 0 in the LSBs
//   lane_sum : signed out_size-bit sum of all lanes
module vacc_lane_reduce #(
  parameter int word_size = 24,
  parameter int lanes     = 4,
  parameter int out_size  = 35
) (
  input  logic [lanes*word_size-1:0] data_in,
  output logic [out_size-1:0]        lane_sum
);

  logic [word_size-1:0] lane_s;
  logic [out_size-1:0]  acc_s;

  // Sign-extend each lane and add it into the running total.
  always_comb begin
    lane_s = '0;
    acc_s  = '0;
    for (int i = 0; i < lanes; i++) begin
      lane_s = data_in[i*word_size +: word_size];
      acc_s  = acc_s + {{(out_size-word_size){lane_s[word_size-1]}}, lane_s};
    end
    lane_sum = acc_s;
  end

endmodule

// File: rtl/vector_accumulate.sv
// vector_accumulate -- reduces len beats of lanes signed elements into one
// signed acc_size-bit sum, with wrap-around or saturating arithmetic and a
// sticky overflow flag.
//   clk, rst          : clock, asynchronous active-high reset
//   start/len/sat_mode: request, beat count and arithmetic mode (IDLE only)
//   data_in/in_valid  : input beat, consumed when in_ready is also high
//   in_ready          : high only while accumulating
//   sum/overflow      : result, held from DONE until the next start
//   out_valid/out_ready: result handshake
//   busy              : high whenever not IDLE
module vector_accumulate
  import vacc_pkg::*;
#(
  parameter int word_size = 24,
  parameter int lanes     = 4,
  parameter int acc_size  = 32,
  parameter int len_size  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [len_size-1:0]        len,
  input  logic                       sat_mode,
  input  logic [lanes*word_size-1:0] data_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [acc_size-1:0]        sum,
  output logic                       overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  // One spare bit above the lane growth keeps sum + lanes exact.
  localparam int ext_size = acc_size + $clog2(lanes) + 1;

  localparam logic signed [ext_size-1:0] max_c =
    {{(ext_size-acc_size+1){1'b0}}, {(acc_size-1){1'b1}}};
  localparam logic signed [ext_size-1:0] min_c =
    {{(ext_size-acc_size+1){1'b1}}, {(acc_size-1){1'b0}}};
  localparam logic [len_size-1:0] one_c = {{(len_size-1){1'b0}}, 1'b1};

  vacc_state_t state_r, next_state_s;

  logic [acc_size-1:0] sum_r;
  logic                overflow_r;
  logic [len_size-1:0] count_r;
  logic                mode_r;

  logic clear_s, load_s, accept_s;

  logic        [ext_size-1:0] lane_sum_s;
  logic signed [ext_size-1:0] exact_s;
  logic                       too_big_s, too_small_s;
  logic        [acc_size-1:0] next_sum_s;

  vacc_lane_reduce #(
    .word_size (word_size),
    .lanes     (lanes),
    .out_size  (ext_size)
  ) u_lane_reduce (
    .data_in  (data_in),
    .lane_sum (lane_sum_s)
  );

  // Exact sum of the beat and the current accumulator, then wrap or clamp.
  always_comb begin
    exact_s     = $signed(lane_sum_s) +
                  $signed({{(ext_size-acc_size){sum_r[acc_size-1]}}, sum_r});
    too_big_s   = (exact_s > max_c);
    too_small_s = (exact_s < min_c);
    if (mode_r == MODE_SAT && too_big_s) begin
      next_sum_s = max_c[acc_size-1:0];
    end else if (mode_r == MODE_SAT && too_small_s) begin
      next_sum_s = min_c[acc_size-1:0];
    end else begin
      next_sum_s = exact_s[acc_size-1:0];
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    load_s       = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          clear_s = 1'b1;
          if (len != '0) begin
            load_s       = 1'b1;
            next_state_s = ACC;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACC: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (count_r == one_c) begin
            next_state_s = DONE;
          end else begin
            next_state_s = ACC;
          end
        end else begin
          next_state_s = ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Accumulator, sticky overflow, beat counter and latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r      <= '0;
      overflow_r <= 1'b0;
      count_r    <= '0;
      mode_r     <= MODE_WRAP;
    end else if (clear_s) begin
      sum_r      <= '0;
      overflow_r <= 1'b0;
      mode_r     <= sat_mode;
      if (load_s) begin
        count_r <= len;
      end else begin
        count_r <= '0;
      end
    end else if (accept_s) begin
      sum_r      <= next_sum_s;
      overflow_r <= overflow_r | too_big_s | too_small_s;
      count_r    <= count_r - one_c;
    end else begin
      sum_r      <= sum_r;
      overflow_r <= overflow_r;
      count_r    <= count_r;
    end
  end

  assign in_ready  = (state_r == ACC);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign sum       = sum_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_vector_accumulate.sv
// tb_vector_accumulate -- directed and randomized checks of vector_accumulate
// against a plain-arithmetic reference model (lanes=4, word_size=24,
// acc_size=32).
module tb_vector_accumulate;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        sat_mode;
  logic [95:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [95:0] bq[$];

  vector_accumulate #(
    .word_size (24),
    .lanes     (4),
    .acc_size  (32),
    .len_size  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .sat_mode  (sat_mode),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pack4(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c, input logic [23:0] d);
    return {d, c, b, a};
  endfunction

  // Reference: exact integer sum per beat, range check, then clamp or wrap.
  function automatic void model(input bit mode, input logic [95:0] q[$],
                                output logic [31:0] s, output logic o);
    longint acc;
    longint t;
    int     w;
    acc = 0;
    o   = 1'b0;
    foreach (q[k]) begin
      t = acc;
      for (int i = 0; i < 4; i++) begin
        t += longint'($signed(q[k][i*24 +: 24]));
      end
      if (t > 64'sd2147483647 || t < -64'sd2147483648) begin
        o = 1'b1;
        if (mode) begin
          acc = (t > 0) ? 64'sd2147483647 : -64'sd2147483648;
        end else begin
          w   = t[31:0];
          acc = w;
        end
      end else begin
        acc = t;
      end
    end
    s = acc[31:0];
  endfunction

  // One full reduction: start, beats with random gaps, optional DONE hold,
  // then a handshake with start also asserted (which must be ignored).
  task automatic run(input int n, input bit m, input logic [95:0] q[$],
                     input int gmax, input int hold, input string tag);
    logic [31:0] es;
    logic        eo;
    model(m, q, es, eo);
    start = 1'b1; len = n[7:0]; sat_mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < q.size(); b++) begin
      repeat ($urandom_range(0, gmax)) begin
        in_valid = 1'b0;
        data_in  = pack4(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
        @(posedge clk); #1;
      end
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      data_in  = q[b];
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    for (int h = 0; h < hold; h++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      data_in  = pack4(24'd100, 24'd100, 24'd100, 24'd100);
      @(posedge clk); #1;
      chk({tag, "_hold_sum"}, sum, es);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
    end
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_sum"}, sum, es);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; sat_mode = 1'b0;
    data_in = 96'd0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("reset_sum", sum, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-beat reduction.
    bq = {pack4(24'd1, 24'd2, 24'd3, 24'd4), pack4(24'd5, 24'd6, 24'd7, 24'd8)};
    run(2, 1'b0, bq, 0, 0, "basic");
    chk("basic_const", sum, 32'd36);

    // Negative lanes with two idle cycles before each beat.
    bq.delete();
    repeat (3) bq.push_back(pack4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF));
    run(3, 1'b0, bq, 0, 0, "neg_nogap");
    chk("neg_const", sum, 32'hFFFFFFF4);
    start = 1'b1; len = 8'd3; sat_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b0;
      data_in  = pack4(24'd7, 24'd7, 24'd7, 24'd7);
      @(posedge clk); @(posedge clk); #1;
      in_valid = 1'b1;
      data_in  = bq[b];
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("gap_out_valid", {31'd0, out_valid}, 32'd1);
    chk("gap_sum", sum, 32'hFFFFFFF4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Positive saturation / wrap / just-below-limit.
    bq.delete();
    repeat (65) bq.push_back(pack4(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF));
    run(65, 1'b1, bq, 0, 0, "sat65");
    chk("sat65_const", sum, 32'h7FFFFFFF);
    chk("sat65_ovf_const", {31'd0, overflow}, 32'd1);
    run(65, 1'b0, bq, 0, 0, "wrap65");
    chk("wrap65_const", sum, 32'h81FFFEFC);
    chk("wrap65_ovf_const", {31'd0, overflow}, 32'd1);
    void'(bq.pop_back());
    run(64, 1'b1, bq, 0, 0, "sat64");
    chk("sat64_const", sum, 32'd2147483392);
    chk("sat64_ovf_const", {31'd0, overflow}, 32'd0);

    // Negative saturation.
    bq.delete();
    repeat (65) bq.push_back(pack4(24'h800000, 24'h800000, 24'h800000, 24'h800000));
    run(65, 1'b1, bq, 0, 0, "negsat");
    chk("negsat_const", sum, 32'h80000000);

    // Backpressure in DONE for five cycles.
    bq = {pack4(24'd9, 24'd1, 24'd1, 24'd1)};
    run(1, 1'b0, bq, 0, 5, "bp");
    chk("bp_const", sum, 32'd12);

    // Zero-length reduction.
    bq.delete();
    run(0, 1'b0, bq, 0, 0, "len0");
    chk("len0_const", sum, 32'd0);

    // Reset in the middle of a reduction.
    start = 1'b1; len = 8'd3; sat_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; data_in = pack4(24'd5, 24'd5, 24'd5, 24'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_sum_before", sum, 32'd20);
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bq = {pack4(24'd10, 24'd0, 24'd0, 24'd0)};
    run(1, 1'b0, bq, 0, 0, "rst_recover");
    chk("rst_recover_const", sum, 32'd10);

    // Randomized reductions against the model.
    for (int r = 0; r < 10; r++) begin
      int n;
      bit m;
      n = $urandom_range(1, 6);
      m = 1'($urandom_range(0, 1));
      bq.delete();
      for (int b = 0; b < n; b++) begin
        bq.push_back(pack4(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)));
      end
      run(n, m, bq, 2, $urandom_range(0, 2), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
